// File: rtl/mem_lsu.sv
// mem_lsu -- pipeline MEM-stage load/store unit with a simple req/ack data bus.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   ex_wd/ex_wreg/ex_wdata        destination info from the EX/MEM register
//   mem_op/mem_addr/mem_sdata     access code (0 none, 1 LB, 2 LBU, 3 LH, 4 LHU,
//                                 5 LW, 6 SB, 7 SH, 8 SW, 9-15 none), address, store data
//   flush                         discard the current instruction
//   mem_wd/mem_wreg/mem_wdata     result towards the MEM/WB register
//   stallreq                      freeze the pipeline while an access is pending
//   dbus_*                        data bus master side (big-endian byte lanes)
//   bus_err                       one-cycle pulse when the watchdog expires
//   misalign                      alignment fault (only with LSU_ALIGN_CHECK_EN)
//   lsu_state                     FSM state for observation (0 IDLE,1 BUSY,2 DONE,3 DRAIN)
//
// Bus handshake: dbus_req rises the edge after an access is accepted and the
// request fields stay stable until the edge at which dbus_ack=1 is sampled
// (or the watchdog expires); dbus_req drops at that same edge. Acks seen while
// no request is outstanding are ignored.
//
// Optional feature: define LSU_ALIGN_CHECK_EN to reject misaligned half/word accesses.
module mem_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  input  logic [31:0] ex_wdata,
  input  logic [3:0]  mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_sdata,
  input  logic        flush,
  output logic [4:0]  mem_wd,
  output logic        mem_wreg,
  output logic [31:0] mem_wdata,
  output logic        stallreq,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_sel,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic        bus_err,
  output logic        misalign,
  output logic [1:0]  lsu_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2, DRAIN = 2'd3} state_t;

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  state_t      state, state_nxt;
  logic [7:0]  wdog;       // completed BUSY/DRAIN cycles without ack
  logic [3:0]  op_q;
  logic [1:0]  off_q;
  logic        timed_out;
  logic [31:0] load_data;

  logic        is_load, is_store, is_access, bad_align, launch, wdog_hit, op_q_load;
  logic [3:0]  sel_nxt;
  logic [31:0] wdata_nxt;

  // Pick the addressed lane (byte 0 is rdata[31:24]) and extend it.
  function automatic logic [31:0] extend_load(input logic [3:0] op, input logic [1:0] off,
                                              input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = rd[31:24];
      2'd1:    b = rd[23:16];
      2'd2:    b = rd[15:8];
      default: b = rd[7:0];
    endcase
    h = off[1] ? rd[15:0] : rd[31:16];
    case (op)
      OP_LB:   extend_load = {{24{b[7]}}, b};
      OP_LBU:  extend_load = {24'd0, b};
      OP_LH:   extend_load = {{16{h[15]}}, h};
      OP_LHU:  extend_load = {16'd0, h};
      default: extend_load = rd;
    endcase
  endfunction

  assign is_load   = (mem_op >= OP_LB) && (mem_op <= OP_LW);
  assign is_store  = (mem_op >= OP_SB) && (mem_op <= OP_SW);
  assign is_access = is_load || is_store;
  assign op_q_load = (op_q >= OP_LB) && (op_q <= OP_LW);

`ifdef LSU_ALIGN_CHECK_EN
  assign bad_align = (((mem_op == OP_LH) || (mem_op == OP_LHU) || (mem_op == OP_SH)) && mem_addr[0]) ||
                     (((mem_op == OP_LW) || (mem_op == OP_SW)) && (mem_addr[1:0] != 2'd0));
`else
  assign bad_align = 1'b0;
`endif

  assign launch   = (state == IDLE) && is_access && !flush && !bad_align;
  // The 255th cycle without ack trips the watchdog.
  assign wdog_hit = (wdog == 8'd254) && !dbus_ack;

  // Lane select and replicated store data for the access being launched.
  always_comb begin
    sel_nxt   = 4'b1111;
    wdata_nxt = mem_sdata;
    case (mem_op)
      OP_LB, OP_LBU, OP_SB: begin
        sel_nxt   = 4'b1000 >> mem_addr[1:0];
        wdata_nxt = {4{mem_sdata[7:0]}};
      end
      OP_LH, OP_LHU, OP_SH: begin
        sel_nxt   = mem_addr[1] ? 4'b0011 : 4'b1100;
        wdata_nxt = {2{mem_sdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (launch) state_nxt = BUSY;
      BUSY: begin
        if (flush)                     state_nxt = (dbus_ack || wdog_hit) ? IDLE : DRAIN;
        else if (dbus_ack || wdog_hit) state_nxt = DONE;
      end
      DONE:  state_nxt = IDLE;
      DRAIN: if (dbus_ack || wdog_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus request registers, watchdog and captured load data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog       <= 8'd0;
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= 32'd0;
      dbus_sel   <= 4'd0;
      dbus_wdata <= 32'd0;
      bus_err    <= 1'b0;
      op_q       <= 4'd0;
      off_q      <= 2'd0;
      timed_out  <= 1'b0;
      load_data  <= 32'd0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            dbus_req   <= 1'b1;
            dbus_we    <= is_store;
            dbus_addr  <= {mem_addr[31:2], 2'b00};
            dbus_sel   <= sel_nxt;
            dbus_wdata <= wdata_nxt;
            op_q       <= mem_op;
            off_q      <= mem_addr[1:0];
            wdog       <= 8'd0;
            timed_out  <= 1'b0;
          end
        end
        BUSY, DRAIN: begin
          if (dbus_ack) begin
            dbus_req  <= 1'b0;
            load_data <= extend_load(op_q, off_q, dbus_rdata);
          end else if (wdog_hit) begin
            dbus_req  <= 1'b0;
            bus_err   <= 1'b1;
            timed_out <= 1'b1;
          end else begin
            wdog <= wdog + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Pipeline-facing outputs; everything reads zero while reset is held.
  always_comb begin
    mem_wd    = ex_wd;
    mem_wreg  = ex_wreg;
    mem_wdata = ex_wdata;
    stallreq  = 1'b0;
    misalign  = 1'b0;
    case (state)
      IDLE: begin
        if (flush) mem_wreg = 1'b0;
        if (is_access && !flush) begin
          if (bad_align) begin
            misalign = 1'b1;
            mem_wreg = 1'b0;
          end else begin
            stallreq = 1'b1;
            mem_wreg = 1'b0;
          end
        end
      end
      BUSY, DRAIN: begin
        stallreq = 1'b1;
        mem_wreg = 1'b0;
      end
      DONE: begin
        mem_wreg  = ex_wreg && !timed_out && !flush;
        mem_wdata = op_q_load ? load_data : ex_wdata;
      end
      default: ;
    endcase
    if (!rst) begin
      mem_wd    = 5'd0;
      mem_wreg  = 1'b0;
      mem_wdata = 32'd0;
      stallreq  = 1'b0;
      misalign  = 1'b0;
    end
  end

  assign lsu_state = state;

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu -- directed, table-driven bench for mem_lsu.
// Inputs change at the falling edge; outputs are sampled 1 ns later.
module tb_mem_lsu;

  logic        clk, rst;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic [3:0]  mem_op;
  logic [31:0] mem_addr, mem_sdata;
  logic        flush;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        stallreq;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_sel;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;
  logic        bus_err, misalign;
  logic [1:0]  lsu_state;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          dly;      // BUSY cycle on which ack is driven
    logic        exwr;
    logic [31:0] exwd;
    logic [3:0]  e_sel;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_bwdata;
    logic [31:0] e_mdata;
  } vec_t;

  vec_t tbl[11];

  mem_lsu dut (
    .clk(clk), .rst(rst),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .mem_op(mem_op), .mem_addr(mem_addr), .mem_sdata(mem_sdata),
    .flush(flush),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .stallreq(stallreq),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_sel(dbus_sel), .dbus_wdata(dbus_wdata),
    .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
    .bus_err(bus_err), .misalign(misalign), .lsu_state(lsu_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata);
    mem_op    = op;
    mem_addr  = addr;
    mem_sdata = sdata;
  endtask

  // One complete access from the table, through DONE.
  task automatic run_vec(input int i, input vec_t v);
    int stall_cnt;
    @(negedge clk);
    ex_wd    = 5'(i + 1);
    ex_wreg  = v.exwr;
    ex_wdata = v.exwd;
    drive_op(v.op, v.addr, v.sdata);
    dbus_ack = 1'b0;
    #1;
    check($sformatf("v%0d_stall_launch", i), 32'(stallreq), 32'd1);
    check($sformatf("v%0d_misalign", i), 32'(misalign), 32'd0);
    stall_cnt = 1;
    for (int c = 1; c <= v.dly; c++) begin
      @(negedge clk);
      dbus_ack   = (c == v.dly);
      dbus_rdata = v.rdata;
      #1;
      if (stallreq) stall_cnt++;
      if (c == 1) begin
        check($sformatf("v%0d_state_busy", i), 32'(lsu_state), 32'd1);
        check($sformatf("v%0d_req", i), 32'(dbus_req), 32'd1);
        check($sformatf("v%0d_sel", i), 32'(dbus_sel), 32'(v.e_sel));
        check($sformatf("v%0d_we", i), 32'(dbus_we), 32'(v.e_we));
        check($sformatf("v%0d_addr", i), dbus_addr, v.e_addr);
        check($sformatf("v%0d_bwdata", i), dbus_wdata, v.e_bwdata);
      end
    end
    @(negedge clk);
    dbus_ack = 1'b0;
    #1;
    check($sformatf("v%0d_stall_cycles", i), 32'(stall_cnt), 32'(v.dly + 1));
    check($sformatf("v%0d_state_done", i), 32'(lsu_state), 32'd2);
    check($sformatf("v%0d_done_stall", i), 32'(stallreq), 32'd0);
    check($sformatf("v%0d_done_req", i), 32'(dbus_req), 32'd0);
    check($sformatf("v%0d_mem_wreg", i), 32'(mem_wreg), 32'(v.exwr));
    check($sformatf("v%0d_mem_wd", i), 32'(mem_wd), 32'(i + 1));
    check($sformatf("v%0d_mem_wdata", i), mem_wdata, v.e_mdata);
  endtask

  initial begin
    int stall_cnt, errs, wreg_seen, done_seen;
    bit seen_done;

    //          op     addr          sdata         rdata         dly wr exwdata       sel      we  bus addr      bus wdata     mem_wdata
    tbl[0]  = '{4'd5, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 3, 1, 32'h1111_0000, 4'b1111, 0, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF};
    tbl[1]  = '{4'd1, 32'h0000_0103, 32'h0,        32'h0000_00F0, 1, 1, 32'h1111_0001, 4'b0001, 0, 32'h0000_0100, 32'h0,        32'hFFFF_FFF0};
    tbl[2]  = '{4'd2, 32'h0000_0103, 32'h0,        32'h0000_00F0, 2, 1, 32'h1111_0002, 4'b0001, 0, 32'h0000_0100, 32'h0,        32'h0000_00F0};
    tbl[3]  = '{4'd1, 32'h0000_0100, 32'h0,        32'h8012_3456, 1, 1, 32'h1111_0003, 4'b1000, 0, 32'h0000_0100, 32'h0,        32'hFFFF_FF80};
    tbl[4]  = '{4'd3, 32'h0000_0102, 32'h0,        32'h1234_8001, 2, 1, 32'h1111_0004, 4'b0011, 0, 32'h0000_0100, 32'h0,        32'hFFFF_8001};
    tbl[5]  = '{4'd4, 32'h0000_0100, 32'h0,        32'h8001_1234, 1, 1, 32'h1111_0005, 4'b1100, 0, 32'h0000_0100, 32'h0,        32'h0000_8001};
    tbl[6]  = '{4'd2, 32'h0000_0101, 32'h0,        32'h00AB_0000, 1, 1, 32'h1111_0006, 4'b0100, 0, 32'h0000_0100, 32'h0,        32'h0000_00AB};
    tbl[7]  = '{4'd7, 32'h0000_0202, 32'h0000_1234, 32'h0,       2, 0, 32'h5000_0007, 4'b0011, 1, 32'h0000_0200, 32'h1234_1234, 32'h5000_0007};
    tbl[8]  = '{4'd6, 32'h0000_0301, 32'h0000_00C3, 32'h0,       1, 0, 32'h5000_0008, 4'b0100, 1, 32'h0000_0300, 32'hC3C3_C3C3, 32'h5000_0008};
    tbl[9]  = '{4'd8, 32'h0000_0400, 32'hCAFE_F00D, 32'hFFFF_FFFF, 3, 0, 32'h5000_0009, 4'b1111, 1, 32'h0000_0400, 32'hCAFE_F00D, 32'h5000_0009};
    tbl[10] = '{4'd5, 32'h0000_010C, 32'h0,        32'h0123_4567, 5, 1, 32'h1111_000A, 4'b1111, 0, 32'h0000_010C, 32'h0,        32'h0123_4567};

    // Reset block: outputs must read zero while rst is low.
    rst = 1'b0; flush = 1'b0; dbus_ack = 1'b0; dbus_rdata = 32'h0;
    ex_wd = 5'h1F; ex_wreg = 1'b1; ex_wdata = 32'hFFFF_FFFF;
    drive_op(4'd5, 32'h104, 32'h55);
    #3;
    check("rst_mem_wd", 32'(mem_wd), 32'd0);
    check("rst_mem_wreg", 32'(mem_wreg), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_stall", 32'(stallreq), 32'd0);
    check("rst_req", 32'(dbus_req), 32'd0);
    check("rst_sel", 32'(dbus_sel), 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    check("rst_misalign", 32'(misalign), 32'd0);
    check("rst_state", 32'(lsu_state), 32'd0);
    drive_op(4'd0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // IDLE pass-through, including an out-of-range code treated as none.
    ex_wd = 5'd7; ex_wreg = 1'b1; ex_wdata = 32'hA5A5_5A5A;
    drive_op(4'd12, 32'h100, 32'h0);
    #1;
    check("pt_wd", 32'(mem_wd), 32'd7);
    check("pt_wreg", 32'(mem_wreg), 32'd1);
    check("pt_wdata", mem_wdata, 32'hA5A5_5A5A);
    check("pt_stall", 32'(stallreq), 32'd0);
    step();
    check("pt_no_req", 32'(dbus_req), 32'd0);
    check("pt_state", 32'(lsu_state), 32'd0);

    // Ack in IDLE is ignored.
    drive_op(4'd0, 32'h0, 32'h0);
    dbus_ack = 1'b1;
    step();
    dbus_ack = 1'b0;
    #1;
    check("idle_ack_state", 32'(lsu_state), 32'd0);
    check("idle_ack_stall", 32'(stallreq), 32'd0);

    // Table-driven accesses.
    for (int i = 0; i < 11; i++) run_vec(i, tbl[i]);

    // Flush in DONE: wreg suppressed, back to IDLE.
    @(negedge clk);
    ex_wreg = 1'b1;
    drive_op(4'd5, 32'h0000_0700, 32'h0);
    @(negedge clk);
    dbus_ack = 1'b1; dbus_rdata = 32'h7777_7777;
    @(negedge clk);
    dbus_ack = 1'b0; flush = 1'b1;
    #1;
    check("fdone_state", 32'(lsu_state), 32'd2);
    check("fdone_wreg", 32'(mem_wreg), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    drive_op(4'd0, 32'h0, 32'h0);
    #1;
    check("fdone_idle", 32'(lsu_state), 32'd0);

    // Flush in IDLE: no request, wreg forced low.
    @(negedge clk);
    ex_wreg = 1'b1; flush = 1'b1;
    drive_op(4'd5, 32'h0000_0800, 32'h0);
    #1;
    check("fidle_wreg", 32'(mem_wreg), 32'd0);
    check("fidle_stall", 32'(stallreq), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    drive_op(4'd0, 32'h0, 32'h0);
    #1;
    check("fidle_no_req", 32'(dbus_req), 32'd0);
    check("fidle_state", 32'(lsu_state), 32'd0);

    // Flush in BUSY, ack two cycles later: DRAIN, no DONE, wreg never high.
    @(negedge clk);
    ex_wreg = 1'b1;
    drive_op(4'd5, 32'h0000_0600, 32'h0);
    wreg_seen = 0; done_seen = 0;
    @(negedge clk);
    flush = 1'b1;
    #1;
    check("fbusy_state", 32'(lsu_state), 32'd1);
    if (mem_wreg) wreg_seen++;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("fbusy_drain", 32'(lsu_state), 32'd3);
    check("fbusy_drain_req", 32'(dbus_req), 32'd1);
    check("fbusy_drain_stall", 32'(stallreq), 32'd1);
    if (mem_wreg) wreg_seen++;
    @(negedge clk);
    dbus_ack = 1'b1; dbus_rdata = 32'h6666_6666;
    #1;
    check("fbusy_ack_stall", 32'(stallreq), 32'd1);
    if (mem_wreg) wreg_seen++;
    @(negedge clk);
    dbus_ack = 1'b0; ex_wreg = 1'b0;
    drive_op(4'd0, 32'h0, 32'h0);
    #1;
    if (lsu_state == 2'd2) done_seen++;
    check("fbusy_after_state", 32'(lsu_state), 32'd0);
    check("fbusy_after_stall", 32'(stallreq), 32'd0);
    check("fbusy_after_req", 32'(dbus_req), 32'd0);
    check("fbusy_no_done", 32'(done_seen), 32'd0);
    check("fbusy_no_wreg", 32'(wreg_seen), 32'd0);

    // Watchdog timeout: 1 launch cycle + 255 BUSY cycles of stall, then DONE.
    @(negedge clk);
    ex_wreg = 1'b1;
    drive_op(4'd5, 32'h0000_0500, 32'h0);
    #1;
    stall_cnt = 0; errs = 0; seen_done = 0;
    for (int c = 0; c < 300; c++) begin
      if (stallreq) stall_cnt++;
      else if (!seen_done) begin
        seen_done = 1;
        check("to_state_done", 32'(lsu_state), 32'd2);
        check("to_wreg", 32'(mem_wreg), 32'd0);
        check("to_err_now", 32'(bus_err), 32'd1);
        drive_op(4'd0, 32'h0, 32'h0);
      end
      if (bus_err) errs++;
      step();
    end
    check("to_seen_done", 32'(seen_done), 32'd1);
    check("to_stall_cycles", 32'(stall_cnt), 32'd256);
    check("to_err_pulses", 32'(errs), 32'd1);
    check("to_idle", 32'(lsu_state), 32'd0);
    check("to_req_low", 32'(dbus_req), 32'd0);

    // Reset during BUSY abandons the access with no DONE cycle.
    @(negedge clk);
    drive_op(4'd5, 32'h0000_0900, 32'h0);
    @(negedge clk);
    #1;
    check("rbusy_state", 32'(lsu_state), 32'd1);
    rst = 1'b0;
    #1;
    check("rbusy_req", 32'(dbus_req), 32'd0);
    check("rbusy_stall", 32'(stallreq), 32'd0);
    check("rbusy_idle", 32'(lsu_state), 32'd0);
    drive_op(4'd0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    step();
    check("rbusy_no_done", 32'(lsu_state), 32'd0);

`ifdef LSU_ALIGN_CHECK_EN
    // Misaligned word: fault flagged, nothing launched, no stall.
    @(negedge clk);
    ex_wreg = 1'b1;
    drive_op(4'd5, 32'h0000_0101, 32'h0);
    #1;
    check("mis_flag", 32'(misalign), 32'd1);
    check("mis_stall", 32'(stallreq), 32'd0);
    check("mis_wreg", 32'(mem_wreg), 32'd0);
    @(negedge clk);
    drive_op(4'd0, 32'h0, 32'h0);
    #1;
    check("mis_no_req", 32'(dbus_req), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
